// File: rtl/flash_responder.sv
// Avalon-MM pipelined read slave. Serves 32-bit words from a synchronous ROM and adds
// programmable wait states, a fixed read latency and a cap on outstanding reads.
module flash_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int LATENCY     = 3,
  parameter int MAX_PENDING = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flash_mem_read,
  input  logic [22:0]                          flash_mem_address,
  output logic                                 flash_mem_waitrequest,
  output logic [31:0]                          flash_mem_readdata,
  output logic                                 flash_mem_readdatavalid,
  output logic [ADDR_BITS-1:0]                 rom_address,
  input  logic [31:0]                          rom_q,
  output logic [$clog2(MAX_PENDING+1)-1:0]     pending_count
);
  localparam int PC_W  = $clog2(MAX_PENDING + 1);
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int LAST  = LATENCY - 2;

  typedef enum logic [1:0] {IDLE, STALL, GRANT} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 wr_q;
  logic [PC_W-1:0]      pend_q;
  logic [ADDR_BITS-1:0] rom_addr_q;
  logic                 issue_q;
  logic [LAST:0]        vld_q;
  logic [31:0]          dat_q [LAST+1];
  logic                 accept;
  logic                 ret;
  logic                 room;

  assign accept = flash_mem_read && !wr_q;
  assign ret    = vld_q[LAST];
  // A return in the deciding cycle frees a slot before the granted accept can land.
  assign room   = (pend_q < PC_W'(MAX_PENDING)) || ret;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b1;
    end else begin
      wr_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (flash_mem_read) begin
            if (WAIT_CYCLES > 0) begin
              state_q <= STALL;
              cnt_q   <= CNT_W'(WAIT_CYCLES);
            end else if (room) begin
              state_q <= GRANT;
              wr_q    <= 1'b0;
            end
          end
        end
        STALL: begin
          if (!flash_mem_read) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_W'(1)) begin
            if (room) begin
              state_q <= GRANT;
              wr_q    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        GRANT:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= '0;
      rom_addr_q <= '0;
      issue_q    <= 1'b0;
    end else begin
      issue_q <= accept;
      if (accept) rom_addr_q <= flash_mem_address[ADDR_BITS-1:0];
      case ({accept, ret})
        2'b10:   pend_q <= pend_q + 1'b1;
        2'b01:   pend_q <= pend_q - 1'b1;
        default: pend_q <= pend_q;
      endcase
    end
  end

  // Stage 0 captures rom_q the edge after the address register was loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q[0] <= 1'b0;
      dat_q[0] <= '0;
    end else begin
      vld_q[0] <= issue_q;
      if (issue_q) dat_q[0] <= rom_q;
    end
  end

  for (genvar gi = 1; gi <= LAST; gi++) begin : g_line
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q[gi] <= 1'b0;
        dat_q[gi] <= '0;
      end else begin
        vld_q[gi] <= vld_q[gi-1];
        if (vld_q[gi-1]) dat_q[gi] <= dat_q[gi-1];
      end
    end
  end

  if (ADDR_BITS < 23) begin : g_alias
    logic unused_upper_addr;
    assign unused_upper_addr = ^flash_mem_address[22:ADDR_BITS];
  end

  assign flash_mem_waitrequest   = wr_q;
  assign flash_mem_readdatavalid = vld_q[LAST];
  assign flash_mem_readdata      = dat_q[LAST];
  assign rom_address             = rom_addr_q;
  assign pending_count           = pend_q;
endmodule

// File: tb/tb_flash_responder.sv
// Directed bench for flash_responder: four instances cover wait states, zero-wait
// streaming, the outstanding cap and reset with reads in flight.
module tb_flash_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return {16'hA5A5, 8'h00, a};
  endfunction

  // A: W2 L3 M2, B: W0 L3 M2, C: W0 L6 M1, D: W0 L6 M2
  logic        read_a = 0, read_b = 0, read_c = 0, read_d = 0;
  logic [22:0] addr_a = 0, addr_b = 0, addr_c = 0, addr_d = 0;
  logic        wr_a, wr_b, wr_c, wr_d, rdv_a, rdv_b, rdv_c, rdv_d;
  logic [31:0] rdata_a, rdata_b, rdata_c, rdata_d, romq_a, romq_b, romq_c, romq_d;
  logic [7:0]  romaddr_a, romaddr_b, romaddr_c, romaddr_d;
  logic [1:0]  pend_a, pend_b, pend_d;
  logic [0:0]  pend_c;

  // ROM array read against the DUT's registered address
  assign romq_a = rom_word(romaddr_a);
  assign romq_b = rom_word(romaddr_b);
  assign romq_c = rom_word(romaddr_c);
  assign romq_d = rom_word(romaddr_d);

  flash_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2), .LATENCY(3), .MAX_PENDING(2)) dut_a (
    .clk(clk), .reset(reset), .flash_mem_read(read_a), .flash_mem_address(addr_a),
    .flash_mem_waitrequest(wr_a), .flash_mem_readdata(rdata_a),
    .flash_mem_readdatavalid(rdv_a), .rom_address(romaddr_a), .rom_q(romq_a),
    .pending_count(pend_a));
  flash_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0), .LATENCY(3), .MAX_PENDING(2)) dut_b (
    .clk(clk), .reset(reset), .flash_mem_read(read_b), .flash_mem_address(addr_b),
    .flash_mem_waitrequest(wr_b), .flash_mem_readdata(rdata_b),
    .flash_mem_readdatavalid(rdv_b), .rom_address(romaddr_b), .rom_q(romq_b),
    .pending_count(pend_b));
  flash_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0), .LATENCY(6), .MAX_PENDING(1)) dut_c (
    .clk(clk), .reset(reset), .flash_mem_read(read_c), .flash_mem_address(addr_c),
    .flash_mem_waitrequest(wr_c), .flash_mem_readdata(rdata_c),
    .flash_mem_readdatavalid(rdv_c), .rom_address(romaddr_c), .rom_q(romq_c),
    .pending_count(pend_c));
  flash_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0), .LATENCY(6), .MAX_PENDING(2)) dut_d (
    .clk(clk), .reset(reset), .flash_mem_read(read_d), .flash_mem_address(addr_d),
    .flash_mem_waitrequest(wr_d), .flash_mem_readdata(rdata_d),
    .flash_mem_readdatavalid(rdv_d), .rom_address(romaddr_d), .rom_q(romq_d),
    .pending_count(pend_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++; if (wr_a !== 1'b1) begin bad++; $display("FAIL reset_wr got=%b want=1", wr_a); end
    total++; if (rdv_a !== 1'b0) begin bad++; $display("FAIL reset_rdv got=%b want=0", rdv_a); end
    total++; if (rdata_a !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata_a); end
    total++; if (romaddr_a !== 8'h0) begin bad++; $display("FAIL reset_romaddr got=%h want=0", romaddr_a); end
    total++; if (pend_a !== 2'd0) begin bad++; $display("FAIL reset_pending got=%0d want=0", pend_a); end
    reset = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  // Held read on A; checks grant delay, latency, data and readdata hold.
  task automatic test_read_a(input string tag, input logic [22:0] addr,
                             input logic [7:0] exp_rom, input logic [31:0] exp_data);
    int n;
    read_a = 1'b1; addr_a = addr;
    n = 0;
    do begin tick(); n++; end while (wr_a && n < 20);
    total++; if (n !== 3) begin bad++; $display("FAIL %s_grant_delay got=%0d want=3", tag, n); end
    tick(); read_a = 1'b0;
    total++; if (pend_a !== 2'd1) begin bad++; $display("FAIL %s_pending got=%0d want=1", tag, pend_a); end
    total++; if (romaddr_a !== exp_rom) begin bad++; $display("FAIL %s_romaddr got=%h want=%h", tag, romaddr_a, exp_rom); end
    n = 1;
    while (!rdv_a && n < 20) begin tick(); n++; end
    total++; if (n !== 3) begin bad++; $display("FAIL %s_latency got=%0d want=3", tag, n); end
    total++; if (rdata_a !== exp_data) begin bad++; $display("FAIL %s_data got=%h want=%h", tag, rdata_a, exp_data); end
    tick();
    total++; if (rdv_a !== 1'b0 || rdata_a !== exp_data) begin
      bad++; $display("FAIL %s_hold got=%b/%h want=0/%h", tag, rdv_a, rdata_a, exp_data); end
    total++; if (pend_a !== 2'd0) begin bad++; $display("FAIL %s_pending_end got=%0d want=0", tag, pend_a); end
    $display("%s addr=%h data=%h", tag, addr, rdata_a);
  endtask

  task automatic test_single_read();
    test_read_a("single", 23'd5, 8'h05, 32'hA5A5_0005);
  endtask

  task automatic test_aliasing();
    test_read_a("alias", 23'h000105, 8'h05, 32'hA5A5_0005);
  endtask

  task automatic test_withdraw();
    int seen;
    read_a = 1'b1; addr_a = 23'd7;
    tick(); read_a = 1'b0;
    seen = 0;
    repeat (12) begin
      tick();
      if (!wr_a || rdv_a || pend_a != 2'd0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL withdraw_activity got=%0d want=0", seen); end
    $display("withdraw activity_cycles=%0d", seen);
  endtask

  task automatic test_streaming();
    int ng, nr, maxp;
    bit prev;
    read_b = 1'b1; addr_b = 23'd0;
    ng = 0; nr = 0; maxp = 0; prev = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (prev) begin
        if (ng == 4) read_b = 1'b0;
        else addr_b = 23'(ng);
      end
      prev = 0;
      if (!wr_b && read_b) begin
        total++; if (c !== 1 + 2 * ng) begin bad++; $display("FAIL stream_grant%0d got=%0d want=%0d", ng, c, 1 + 2 * ng); end
        ng++; prev = 1;
      end
      if (rdv_b) begin
        total++; if (c !== 4 + 2 * nr) begin bad++; $display("FAIL stream_ret%0d_cycle got=%0d want=%0d", nr, c, 4 + 2 * nr); end
        total++; if (rdata_b !== rom_word(8'(nr))) begin bad++; $display("FAIL stream_ret%0d_data got=%h want=%h", nr, rdata_b, rom_word(8'(nr))); end
        $display("stream return %0d cycle=%0d data=%h", nr, c, rdata_b);
        nr++;
      end
      if (int'(pend_b) > maxp) maxp = int'(pend_b);
    end
    total++; if (ng !== 4 || nr !== 4) begin bad++; $display("FAIL stream_counts got=%0d/%0d want=4/4", ng, nr); end
    total++; if (maxp > 2) begin bad++; $display("FAIL stream_max_pending got=%0d want<=2", maxp); end
  endtask

  task automatic test_outstanding_cap();
    int ng, nr;
    int gcyc [2];
    int rcyc [2];
    bit prev;
    read_c = 1'b1; addr_c = 23'd0;
    ng = 0; nr = 0; prev = 0;
    gcyc[0] = -1; gcyc[1] = -1; rcyc[0] = -1; rcyc[1] = -1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (prev && ng == 1) addr_c = 23'd1;
      if (prev && ng == 2) read_c = 1'b0;
      prev = 0;
      if (!wr_c && read_c && ng < 2) begin gcyc[ng] = c; ng++; prev = 1; end
      if (rdv_c && nr < 2) begin
        total++; if (rdata_c !== rom_word(8'(nr))) begin bad++; $display("FAIL cap_data%0d got=%h want=%h", nr, rdata_c, rom_word(8'(nr))); end
        rcyc[nr] = c; nr++;
      end
    end
    total++; if (gcyc[0] !== 1) begin bad++; $display("FAIL cap_grant0 got=%0d want=1", gcyc[0]); end
    total++; if (rcyc[0] !== 7) begin bad++; $display("FAIL cap_ret0 got=%0d want=7", rcyc[0]); end
    total++; if (gcyc[1] !== 8) begin bad++; $display("FAIL cap_grant1 got=%0d want=8", gcyc[1]); end
    total++; if (rcyc[1] !== 14) begin bad++; $display("FAIL cap_ret1 got=%0d want=14", rcyc[1]); end
    $display("cap grants=%0d,%0d returns=%0d,%0d", gcyc[0], gcyc[1], rcyc[0], rcyc[1]);
  endtask

  task automatic test_reset_inflight();
    int seen, n;
    read_d = 1'b1; addr_d = 23'h10;
    tick();
    total++; if (wr_d !== 1'b0) begin bad++; $display("FAIL rst_grant0 got=%b want=0", wr_d); end
    tick(); addr_d = 23'h11;
    tick();
    total++; if (wr_d !== 1'b0) begin bad++; $display("FAIL rst_grant1 got=%b want=0", wr_d); end
    tick(); read_d = 1'b0;
    total++; if (pend_d !== 2'd2) begin bad++; $display("FAIL rst_pending_before got=%0d want=2", pend_d); end
    reset = 1'b1;
    tick(); reset = 1'b0;
    total++; if (pend_d !== 2'd0 || wr_d !== 1'b1 || rdv_d !== 1'b0) begin
      bad++; $display("FAIL rst_after got=p%0d/w%b/v%b want=p0/w1/v0", pend_d, wr_d, rdv_d); end
    seen = 0;
    repeat (12) begin tick(); if (rdv_d || !wr_d) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_no_return got=%0d want=0", seen); end
    read_d = 1'b1; addr_d = 23'h12;
    n = 0;
    do begin tick(); n++; end while (wr_d && n < 20);
    total++; if (n !== 1) begin bad++; $display("FAIL rst_next_grant got=%0d want=1", n); end
    tick(); read_d = 1'b0;
    n = 1;
    while (!rdv_d && n < 20) begin tick(); n++; end
    total++; if (n !== 6) begin bad++; $display("FAIL rst_next_latency got=%0d want=6", n); end
    total++; if (rdata_d !== 32'hA5A5_0012) begin bad++; $display("FAIL rst_next_data got=%h want=a5a50012", rdata_d); end
    $display("reset_inflight next data=%h", rdata_d);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_aliasing();
    test_withdraw();
    test_streaming();
    test_outstanding_cap();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
